// File: rtl/noise_generator_lfsr.sv
// noise_generator_lfsr: multi-channel audio noise source.
// Each sample strobe produces one signed sample per channel. The modes are
// off, 3-bit sawtooth, and per-channel decorrelated Galois LFSR white noise.
// Amplitude is set by an arithmetic right shift. The LFSRs can be reseeded.
// Optional build macro NOISE_TPDF_EN: in LFSR mode each channel outputs the
// average of its current and previous sample, which gives triangular-PDF noise.
module noise_generator_lfsr #(
    parameter int unsigned       DATA_W     = 24,
    parameter int unsigned       LFSR_W     = 16,
    parameter int unsigned       CHANNELS   = 2,
    parameter int unsigned       SAW_SHIFT  = 11,
    parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic [4:0]                 amp_shift,
    input  logic                       seed_load,
    input  logic [LFSR_W-1:0]          seed,
    output logic [CHANNELS*DATA_W-1:0] Q,
    output logic                       q_valid
);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_SAW  = 2'b01,
        MODE_LFSR = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(16'hB400);

    // Rotate left by c positions. Each channel starts from a rotated copy of
    // the seed so that the channels are decorrelated.
    function automatic logic [LFSR_W-1:0] rotl(input logic [LFSR_W-1:0] v,
                                               input int unsigned c);
        logic [LFSR_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LFSR_W; i++) begin
            r[(i + c) % LFSR_W] = v[i];
        end
        return r;
    endfunction

    // Galois right-shift step. A nonzero state never maps to zero.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAP_MASK : '0);
    endfunction

    logic [LFSR_W-1:0]          r_lfsr [CHANNELS];
    logic [2:0]                 r_saw;
    logic [CHANNELS*DATA_W-1:0] r_q;
    logic                       r_valid;
`ifdef NOISE_TPDF_EN
    logic signed [DATA_W-1:0]   r_prev [CHANNELS];
`endif

    mode_e                    w_mode;
    logic [LFSR_W-1:0]        w_seed_eff;
    logic signed [DATA_W-1:0] w_saw_ext;
    logic signed [DATA_W-1:0] w_cur [CHANNELS];
    logic signed [DATA_W-1:0] w_raw [CHANNELS];
    logic signed [DATA_W-1:0] w_out [CHANNELS];

    assign w_mode     = mode_e'(mode);
    assign w_seed_eff = (seed == '0) ? RESET_SEED : seed;

    // Raw and attenuated sample per channel, computed from the current state.
    always_comb begin
        w_saw_ext = {{(DATA_W-3){r_saw[2]}}, r_saw} << SAW_SHIFT;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_cur[c] = DATA_W'(r_lfsr[c]) << (DATA_W - LFSR_W);
            case (w_mode)
                MODE_SAW:  w_raw[c] = w_saw_ext;
`ifdef NOISE_TPDF_EN
                MODE_LFSR: w_raw[c] = (w_cur[c] >>> 1) + (r_prev[c] >>> 1);
`else
                MODE_LFSR: w_raw[c] = w_cur[c];
`endif
                default:   w_raw[c] = '0;
            endcase
            w_out[c] = w_raw[c] >>> amp_shift;
        end
    end

    // State update. Reset has the highest priority, then seed reload, then the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            r_valid <= 1'b0;
            r_saw   <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_lfsr[c] <= rotl(RESET_SEED, c);
`ifdef NOISE_TPDF_EN
                r_prev[c] <= '0;
`endif
            end
        end else if (seed_load) begin
            r_valid <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_lfsr[c] <= rotl(w_seed_eff, c);
`ifdef NOISE_TPDF_EN
                r_prev[c] <= '0;
`endif
            end
        end else if (enable) begin
            r_valid <= 1'b1;
            r_saw   <= r_saw + 3'd1;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_q[c*DATA_W +: DATA_W] <= w_out[c];
                r_lfsr[c]               <= lfsr_step(r_lfsr[c]);
`ifdef NOISE_TPDF_EN
                r_prev[c]               <= w_cur[c];
`endif
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign Q       = r_q;
    assign q_valid = r_valid;

endmodule
